// File: rtl/i2c_merge_ctrl.sv
// Bus-state tracker and round-robin mask arbiter for the two-bus I2C fan-out.
// A new enable mask is applied only while the merged bus is idle past t_BUF.
module i2c_merge_ctrl #(
   parameter int         SYNC_STAGES    = 2,
   parameter int         BUF_CYCLES     = 100,
   parameter int         TIMEOUT_CYCLES = 1000000,
   parameter logic [1:0] DEFAULT_MASK   = 2'b11
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   input  logic       req0_valid,
   input  logic [1:0] req0_mask,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [1:0] req1_mask,
   output logic       req1_ready,
   output logic [1:0] enable_o,
   output logic       bus_busy_o,
   output logic       timeout_o
);

   localparam int GAP_W = $clog2(BUF_CYCLES) + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BUF_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      BUSY  = 2'd2,
      GAP   = 2'd3
   } state_t;

   function automatic logic [GAP_W-1:0] gap_inc(input logic [GAP_W-1:0] v);
      gap_inc = (v == {GAP_W{1'b1}}) ? v : v + GAP_W'(1);
   endfunction

   function automatic logic [TO_W-1:0] to_inc(input logic [TO_W-1:0] v);
      to_inc = (v == {TO_W{1'b1}}) ? v : v + TO_W'(1);
   endfunction

   logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
   logic                   scl_prev_r, sda_prev_r;
   logic                   scl_s, sda_s, start_s, stop_s, scl_edge_s, both_high_s;

   state_t           state_r, state_nxt_s;
   logic [GAP_W-1:0] gap_cnt_r, gap_nxt_s;
   logic [TO_W-1:0]  to_cnt_r, to_nxt_s;
   logic             last_r;
   logic             grant0_s, grant1_s, do_grant_s, to_fire_s;
   logic [1:0]       grant_mask_s;
   logic [1:0]       enable_r;
   logic             ready0_r, ready1_r, busy_r, timeout_r;

   // Line synchronizers plus one extra copy for edge detection; idle level is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_r <= {SYNC_STAGES{1'b1}};
         sda_sync_r <= {SYNC_STAGES{1'b1}};
         scl_prev_r <= 1'b1;
         sda_prev_r <= 1'b1;
      end else begin
         scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
         sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
         scl_prev_r <= scl_sync_r[SYNC_STAGES-1];
         sda_prev_r <= sda_sync_r[SYNC_STAGES-1];
      end
   end

   assign scl_s       = scl_sync_r[SYNC_STAGES-1];
   assign sda_s       = sda_sync_r[SYNC_STAGES-1];
   assign start_s     = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
   assign stop_s      = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
   assign scl_edge_s  = scl_s ^ scl_prev_r;
   assign both_high_s = scl_s & sda_s;

   // Round-robin pick: on a tie the requester that did not win last time goes.
   always_comb begin
      grant0_s     = 1'b0;
      grant1_s     = 1'b0;
      grant_mask_s = req0_mask;
      if (req0_valid && req1_valid) begin
         grant0_s = last_r;
         grant1_s = ~last_r;
      end else begin
         grant0_s = req0_valid;
         grant1_s = req1_valid;
      end
      if (grant1_s) begin
         grant_mask_s = req1_mask;
      end else begin
         grant_mask_s = req0_mask;
      end
   end

   // Bus-state next-state logic; counters default to cleared outside their state.
   always_comb begin
      state_nxt_s = state_r;
      gap_nxt_s   = '0;
      to_nxt_s    = '0;
      do_grant_s  = 1'b0;
      to_fire_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               state_nxt_s = BUSY;
            end else if (req0_valid || req1_valid) begin
               state_nxt_s = APPLY;
               do_grant_s  = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         APPLY: begin
            if (start_s) begin
               state_nxt_s = BUSY;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BUSY: begin
            if (start_s) begin
               state_nxt_s = BUSY;
            end else if (stop_s) begin
               state_nxt_s = GAP;
            end else if (to_cnt_r >= TO_LAST) begin
               state_nxt_s = GAP;
               to_fire_s   = 1'b1;
            end else begin
               to_nxt_s = scl_edge_s ? '0 : to_inc(to_cnt_r);
            end
         end
         GAP: begin
            if (start_s) begin
               state_nxt_s = BUSY;
            end else if (gap_cnt_r >= GAP_LAST) begin
               state_nxt_s = IDLE;
            end else begin
               gap_nxt_s = both_high_s ? gap_inc(gap_cnt_r) : '0;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, counters, arbitration pointer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         gap_cnt_r <= '0;
         to_cnt_r  <= '0;
         last_r    <= 1'b1;
         enable_r  <= DEFAULT_MASK;
         ready0_r  <= 1'b0;
         ready1_r  <= 1'b0;
         busy_r    <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         gap_cnt_r <= gap_nxt_s;
         to_cnt_r  <= to_nxt_s;
         ready0_r  <= do_grant_s & grant0_s;
         ready1_r  <= do_grant_s & grant1_s;
         busy_r    <= (state_r == BUSY) || (state_r == GAP);
         timeout_r <= to_fire_s;
         if (do_grant_s) begin
            last_r   <= grant1_s;
            enable_r <= grant_mask_s;
         end else begin
            last_r   <= last_r;
            enable_r <= enable_r;
         end
      end
   end

   assign enable_o   = enable_r;
   assign req0_ready = ready0_r;
   assign req1_ready = ready1_r;
   assign bus_busy_o = busy_r;
   assign timeout_o  = timeout_r;

endmodule

// File: tb/tb_i2c_merge_ctrl.sv
// Randomized bench for i2c_merge_ctrl: expected grant, busy and timeout events are
// predicted as absolute cycle numbers from bus-event times and compared on the fly.
module tb_i2c_merge_ctrl;

   localparam int BUF = 16;
   localparam int TO  = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       sda = 1'b1;
   logic       req0_valid = 1'b0;
   logic       req1_valid = 1'b0;
   logic [1:0] req0_mask = 2'b00;
   logic [1:0] req1_mask = 2'b00;
   logic       req0_ready, req1_ready, bus_busy_o, timeout_o;
   logic [1:0] enable_o;

   typedef struct {
      int id;
      int mask;
      int cyc;
   } grant_t;

   grant_t exp_grants[$];
   int     exp_busy[$];
   int     exp_to[$];
   grant_t g;
   int     cyc = 0;
   int     n_pass = 0;
   int     n_total = 0;
   int     exp_en = 3;
   int     last_id = 1;
   int     last_scl = 0;
   logic   prev_busy = 1'b0;
   int     mon_id;
   int     ev;

   i2c_merge_ctrl #(
      .SYNC_STAGES   (2),
      .BUF_CYCLES    (BUF),
      .TIMEOUT_CYCLES(TO),
      .DEFAULT_MASK  (2'b11)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_i     (scl),
      .sda_i     (sda),
      .req0_valid(req0_valid),
      .req0_mask (req0_mask),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid),
      .req1_mask (req1_mask),
      .req1_ready(req1_ready),
      .enable_o  (enable_o),
      .bus_busy_o(bus_busy_o),
      .timeout_o (timeout_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_total++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Grants the model expects once the bus is idle during cycle c.
   task automatic predict_grants(input int c);
      int w;
      if (req0_valid && req1_valid) begin
         w = (last_id == 1) ? 0 : 1;
         exp_grants.push_back('{w, (w == 0) ? int'(req0_mask) : int'(req1_mask), c + 1});
         exp_grants.push_back('{1 - w, (w == 0) ? int'(req1_mask) : int'(req0_mask), c + 3});
         last_id = 1 - w;
      end else if (req0_valid) begin
         exp_grants.push_back('{0, int'(req0_mask), c + 1});
         last_id = 0;
      end else if (req1_valid) begin
         exp_grants.push_back('{1, int'(req1_mask), c + 1});
         last_id = 1;
      end
   endtask

   task automatic raise(input int id, input int m);
      if ((id == 0 || id == 2) && !req0_valid) begin
         req0_mask  = (m >= 0) ? 2'(m) : 2'($urandom_range(0, 3));
         req0_valid = 1'b1;
      end
      if ((id == 1 || id == 2) && !req1_valid) begin
         req1_mask  = (m >= 0) ? 2'(m) : 2'($urandom_range(0, 3));
         req1_valid = 1'b1;
      end
   endtask

   task automatic idle_req(input int id, input int m);
      raise(id, m);
      predict_grants(cyc);
      tick(6);
   endtask

   task automatic start_cond(input int coinc, input int m);
      int s;
      sda = 1'b0;
      s = cyc;
      exp_busy.push_back(s + 4);
      tick(2);
      if (coinc >= 0) raise(coinc, m);
      tick(2);
      scl = 1'b0;
      last_scl = cyc;
      tick(2);
   endtask

   task automatic send_bit();
      sda = 1'($urandom_range(0, 1));
      tick(2);
      scl = 1'b1;
      tick(3);
      scl = 1'b0;
      last_scl = cyc;
      tick(2);
   endtask

   task automatic rep_start();
      sda = 1'b1;
      tick(2);
      scl = 1'b1;
      tick(4);
      sda = 1'b0;
      tick(4);
      scl = 1'b0;
      last_scl = cyc;
      tick(2);
   endtask

   task automatic transaction(input int nbits, input int coinc, input int mid_id,
                              input int mid_at, input int nrep, input bit to, input int m);
      int p;
      start_cond(coinc, m);
      for (int i = 0; i < nbits; i++) begin
         if (i == mid_at && mid_id >= 0) raise(mid_id, m);
         send_bit();
      end
      for (int i = 0; i < nrep; i++) rep_start();
      if (to) begin
         exp_to.push_back(last_scl + TO + 3);
         tick(TO + 12);
         sda = 1'b1;
         tick(2);
         scl = 1'b1;
         p = cyc;
         predict_grants(p + BUF + 2);
         exp_busy.push_back(p + BUF + 3);
      end else begin
         sda = 1'b0;
         tick(2);
         scl = 1'b1;
         tick(3);
         sda = 1'b1;
         p = cyc;
         predict_grants(p + BUF + 3);
         exp_busy.push_back(p + BUF + 4);
      end
      tick(BUF + 12);
   endtask

   task automatic reset_midop();
      idle_req($urandom_range(0, 2), -1);
      start_cond(-1, -1);
      raise($urandom_range(0, 2), -1);
      send_bit();
      send_bit();
      rst_n = 1'b0;
      #1;
      check_eq("rst_enable", int'(enable_o), 3);
      check_eq("rst_busy", int'(bus_busy_o), 0);
      check_eq("rst_ready", int'({req1_ready, req0_ready}), 0);
      exp_grants.delete();
      exp_busy.delete();
      exp_to.delete();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      scl = 1'b1;
      sda = 1'b1;
      exp_en = 3;
      last_id = 1;
      tick(3);
      rst_n = 1'b1;
      tick(20);
   endtask

   // Event monitor: every ready, busy edge and timeout must match the next prediction.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_busy = bus_busy_o;
         end else begin
            if (req0_ready && req1_ready) check_eq("dual_ready", 1, 0);
            if (req0_ready || req1_ready) begin
               mon_id = req0_ready ? 0 : 1;
               if (exp_grants.size() == 0) begin
                  check_eq("grant_unexpected", mon_id, -1);
               end else begin
                  g = exp_grants.pop_front();
                  check_eq("grant_id", mon_id, g.id);
                  check_eq("grant_cycle", cyc, g.cyc);
                  check_eq("grant_mask", int'(enable_o), g.mask);
                  exp_en = g.mask;
               end
               if (req0_ready) req0_valid = 1'b0;
               if (req1_ready) req1_valid = 1'b0;
            end else begin
               check_eq("enable_hold", int'(enable_o), exp_en);
            end
            if (bus_busy_o != prev_busy) begin
               if (exp_busy.size() == 0) begin
                  check_eq("busy_unexpected", int'(bus_busy_o), int'(prev_busy));
               end else begin
                  ev = exp_busy.pop_front();
                  check_eq("busy_edge_cycle", cyc, ev);
               end
            end
            if (timeout_o) begin
               if (exp_to.size() == 0) begin
                  check_eq("timeout_unexpected", 1, 0);
               end else begin
                  ev = exp_to.pop_front();
                  check_eq("timeout_cycle", cyc, ev);
               end
            end
            prev_busy = bus_busy_o;
         end
      end
   end

   initial begin
      int nb;
      int kind;
      tick(3);
      rst_n = 1'b1;
      check_eq("reset_enable", int'(enable_o), 3);
      check_eq("reset_busy", int'(bus_busy_o), 0);
      check_eq("reset_ready", int'({req1_ready, req0_ready}), 0);
      check_eq("reset_timeout", int'(timeout_o), 0);
      tick(1000);

      idle_req(0, 1);
      transaction(8, -1, 1, 3, 0, 1'b0, 2);
      idle_req(2, -1);
      idle_req(2, -1);
      transaction(4, -1, 0, 2, 0, 1'b1, -1);
      transaction(6, 2, -1, 0, 2, 1'b0, -1);

      for (int it = 0; it < 30; it++) begin
         kind = $urandom_range(0, 9);
         if (kind <= 3) begin
            idle_req($urandom_range(0, 2), -1);
         end else if (kind <= 7) begin
            nb = $urandom_range(1, 18);
            transaction(nb, $urandom_range(0, 3) - 1, $urandom_range(0, 3) - 1,
                        $urandom_range(0, nb - 1), $urandom_range(0, 2), 1'b0, -1);
         end else if (kind == 8) begin
            nb = $urandom_range(1, 9);
            transaction(nb, -1, $urandom_range(0, 3) - 1, $urandom_range(0, nb - 1),
                        0, 1'b1, -1);
         end else begin
            reset_midop();
         end
      end

      tick(10);
      check_eq("grants_pending", exp_grants.size(), 0);
      check_eq("busy_pending", exp_busy.size(), 0);
      check_eq("timeout_pending", exp_to.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
